// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard for the venus decode stage.
// Flags RAW/WAW stalls, tracks reservations and sequences register drains.
module reg_scoreboard #(
    parameter int NREG = 32,
    parameter int W_RD = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            check_v,
    input  logic            src0_en,
    input  logic            src1_en,
    input  logic [W_RD-1:0] src0,
    input  logic [W_RD-1:0] src1,
    input  logic            dst_en,
    input  logic [W_RD-1:0] dst,
    input  logic            reserve_i,
    input  logic            wb_v,
    input  logic [W_RD-1:0] wb_r,
    input  logic            kill_v,
    input  logic [W_RD-1:0] kill_r,
    input  logic            flush_i,
    input  logic            drain_req,
    output logic            reserved_o,
    output logic            busy_o,
    output logic            drain_ack_o,
    output logic [NREG-1:0] pend_o,
    output logic            err_o
);

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        ACK
    } state_e;

    state_e          state_q, state_d;
    logic [NREG-1:0] pend_q, pend_d;
    logic [NREG-1:0] set_vec, wb_vec, kill_vec, clr_vec;
    logic            err_q, err_d;
    logic            res, err_ev;

    // Hazard uses registered state only: releases free a register next cycle.
    assign reserved_o = check_v & ((src0_en & pend_q[src0]) |
                                   (src1_en & pend_q[src1]) |
                                   (dst_en & pend_q[dst]) |
                                   (state_q != IDLE));

    assign res = reserve_i & check_v & dst_en & ~reserved_o;

    always_comb begin
        set_vec  = '0;
        wb_vec   = '0;
        kill_vec = '0;
        if (res)    set_vec[dst]     = 1'b1;
        if (wb_v)   wb_vec[wb_r]     = 1'b1;
        if (kill_v) kill_vec[kill_r] = 1'b1;
        clr_vec = wb_vec | kill_vec;
        // Set wins over a same-register clear; that case also raises err.
        pend_d = flush_i ? '0 : ((pend_q & ~clr_vec) | set_vec);
    end

    always_comb begin
        err_ev = (wb_v & ~pend_q[wb_r]) |
                 (kill_v & ~pend_q[kill_r]) |
                 (wb_v & kill_v & (wb_r == kill_r)) |
                 (reserve_i & check_v & dst_en & reserved_o) |
                 (|(set_vec & clr_vec));
        err_d = err_q | (err_ev & ~flush_i);
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (drain_req) state_d = DRAIN;
            DRAIN:   if (pend_q == '0) state_d = ACK;
            ACK:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            pend_q  <= '0;
            state_q <= IDLE;
            err_q   <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    assign busy_o      = |pend_q;
    assign pend_o      = pend_q;
    assign drain_ack_o = (state_q == ACK);
    assign err_o       = err_q;

endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Register-reservation scoreboard that serves the decode stage of the venus pipeline. It tracks one pending-write bit per architectural register. It tells decode whether the instruction it holds must stall on a RAW or WAW hazard, accepts decode's write reservation, and clears reservations when the writeback stage retires a write or a squashed instruction is cancelled. It also includes a drain sequencer so control logic can wait until no register write is outstanding.

## Interface
- NREG, 32, number of architectural registers tracked
- W_RD, 5, register index width; NREG = 2**W_RD
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  reset is synchronous and active-low; clears all state on the rising edge where reset==0
- check_v  in  1  decode holds a valid instruction to be checked this cycle
- src0_en, src1_en  in  1 each  the instruction reads src0 / src1
- src0, src1  in  W_RD each  source register indices
- dst_en  in  1  the instruction writes dst
- dst  in  W_RD  destination register index
- reserve_i  in  1  decode accepts the instruction this cycle (valid & not stalled); requests reservation of dst
- wb_v  in  1  writeback retires a register write
- wb_r  in  W_RD  register retired by writeback
- kill_v  in  1  a reserved instruction was squashed (branch); release its reservation
- kill_r  in  W_RD  register of the squashed reservation
- flush_i  in  1  full pipeline flush; clear all reservations
- drain_req  in  1  request to wait until no writes are outstanding
- reserved_o  out  1  hazard: decode must stall
- busy_o  out  1  at least one pending bit is set (registered)
- drain_ack_o  out  1  one-cycle pulse: drain is complete
- pend_o  out  NREG  pending-bit vector (registered)
- err_o  out  1  sticky protocol-error flag

## Operation
- State: pend[NREG-1:0], FSM {IDLE, DRAIN, ACK}, err.
- reserved_o is combinational from the registered state only. No same-cycle bypass of releases.
  - reserved_o = check_v & ( (src0_en & pend[src0]) | (src1_en & pend[src1]) | (dst_en & pend[dst]) | (state != IDLE) ).
- Effective reserve: res = reserve_i & check_v & dst_en & ~reserved_o.
- Per-register next pend, in priority order:
  1. reset==0 → 0.
  2. flush_i → 0. Concurrent reserves and releases are ignored.
  3. Otherwise set if res & dst==i. Clear if (wb_v & wb_r==i) or (kill_v & kill_r==i).
- Set and clear on the same register in the same cycle cannot occur legally, because res requires pend[dst]==0 and a release requires pend==1. If it does occur, set wins and err is raised.
- err is set (sticky until reset) when any of the following happens without flush_i:
  - wb_v or kill_v targets a register whose pend==0;
  - wb_v and kill_v target the same register in the same cycle;
  - reserve_i & check_v & dst_en while reserved_o==1.
- Drain FSM:
  - IDLE: drain_req → DRAIN.
  - DRAIN: when pend==0 (registered value) → ACK. drain_req is ignored while in DRAIN.
  - ACK: drain_ack_o=1 → IDLE unconditionally.
  - Throughout DRAIN and ACK, any check_v stalls, so no new reservation can enter.
  - flush_i while in DRAIN clears pend. Pend is then zero on the next cycle, so the FSM reaches ACK one cycle later.
- busy_o = |pend (registered). pend_o = pend.

## Timing
- Reset values: pend=0, state=IDLE, err_o=0, busy_o=0, drain_ack_o=0, pend_o=0. reserved_o=0 whenever check_v=0, and also right after reset.
- Reserve at edge t: pend[dst] is visible from cycle t+1. A dependent instruction checked in cycle t+1 sees reserved_o=1.
- Release in cycle t: the register frees at t+1. reserved_o for that register falls in cycle t+1 (one-cycle writeback-to-issue penalty; no bypass).
- Drain latency:
  - drain_req at cycle t with pend already 0: DRAIN in t+1, ACK (drain_ack_o=1) in t+2, IDLE in t+3.
  - Otherwise ACK comes 1 cycle after the cycle in which pend first reads zero.
- reset asserted mid-drain: FSM returns to IDLE, and drain_ack_o is not pulsed.

## Test plan
- Reset, then check_v=1 with src0=3, src1=4, dst=5, all enables set, reserve_i=1 → reserved_o=0; pend_o==0x20 next cycle, busy_o=1.
- After reserving r5, check src0=5 → reserved_o=1. wb_v=1, wb_r=5 in cycle t → reserved_o=1 in t, 0 in t+1; pend_o==0.
- Reserve r7 → pend_o==0x80. Check dst=7 with sources disabled → reserved_o=1 (WAW). kill_v=1, kill_r=7 → pend_o==0, err_o=0.
- Reserve r1 and r2, then flush_i=1 together with reserve_i for r3 → pend_o==0 next cycle; r3 not reserved.
- pend has r9 set; pulse drain_req → reserved_o=1 for any check_v. wb_r=9 retires at cycle t → drain_ack_o pulses 1 cycle in t+2, then IDLE; drain_req with empty pend → ack exactly 2 cycles later.
- wb_v=1, wb_r=12 while pend[12]=0 → err_o=1 next cycle and stays 1 until reset; reset low for 1 cycle → err_o=0.
